// File: rtl/line_buffer_window.sv
// Line buffer producing a ROWS-tall pixel column per accepted pixel, with row/column
// indices, window-anchor flag at a fixed stride, and an end-of-frame pulse.
module line_buffer_window #(
    parameter int DATA_W = 16,
    parameter int LINE_W = 32,
    parameter int ROWS   = 4,
    parameter int STRIDE = 2,
    parameter int IDX_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [IDX_W-1:0]         line_len,
    input  logic [IDX_W-1:0]         frame_h,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    output logic [ROWS*DATA_W-1:0]   col_data,
    output logic [IDX_W-1:0]         col_idx,
    output logic [IDX_W-1:0]         row_idx,
    output logic                     win_valid,
    output logic                     frame_done
);

    localparam int PTR_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [IDX_W-1:0] LEN_MAX     = IDX_W'(LINE_W);
    localparam logic [IDX_W-1:0] ROW_LAST    = IDX_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] STRIDE_MASK = IDX_W'(STRIDE - 1);

    logic [DATA_W-1:0] line_mem [0:ROWS-2][0:LINE_W-1];

    logic [IDX_W-1:0]       col_q, col_d, row_q, row_d;
    logic [IDX_W-1:0]       len_q, len_d, h_q, h_d;
    logic                   idle_q, idle_d;
    logic                   out_valid_q, out_valid_d;
    logic [ROWS*DATA_W-1:0] col_data_q, col_data_d;
    logic [IDX_W-1:0]       col_idx_q, col_idx_d, row_idx_q, row_idx_d;
    logic                   win_valid_q, win_valid_d;
    logic                   frame_done_q, frame_done_d;

    logic [IDX_W-1:0] len_in, h_in, len_eff, h_eff;
    logic             col_last, row_last, accept;
    logic [PTR_W-1:0] ptr;

    // The write pointer always equals the column counter, so one register serves both.
    assign ptr    = col_q[PTR_W-1:0];
    assign accept = in_valid & ~clr & ~rst;

    always_comb begin
        len_in   = (line_len == '0 || line_len > LEN_MAX) ? LEN_MAX : line_len;
        h_in     = (frame_h == '0) ? '1 : frame_h;
        len_eff  = idle_q ? len_in : len_q;
        h_eff    = idle_q ? h_in : h_q;
        col_last = (col_q == len_eff - IDX_W'(1));
        row_last = (row_q == h_eff - IDX_W'(1));

        col_d        = col_q;
        row_d        = row_q;
        len_d        = len_q;
        h_d          = h_q;
        idle_d       = idle_q;
        out_valid_d  = 1'b0;
        col_data_d   = col_data_q;
        col_idx_d    = col_idx_q;
        row_idx_d    = row_idx_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        if (accept) begin
            len_d       = len_eff;
            h_d         = h_eff;
            idle_d      = 1'b0;
            out_valid_d = 1'b1;
            col_idx_d   = col_q;
            row_idx_d   = row_q;
            col_data_d[DATA_W-1:0] = in_data;
            // Rows not yet filled in this frame read as zero rather than stale RAM.
            for (int r = 1; r < ROWS; r++) begin
                col_data_d[r*DATA_W +: DATA_W] =
                    (row_q >= IDX_W'(r)) ? line_mem[r-1][ptr] : '0;
            end
            win_valid_d = (row_q >= ROW_LAST) && (col_q >= ROW_LAST)
                        && (((row_q - ROW_LAST) & STRIDE_MASK) == '0)
                        && (((col_q - ROW_LAST) & STRIDE_MASK) == '0);
            frame_done_d = col_last & row_last;
            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d  = '0;
                    idle_d = 1'b1;
                end else begin
                    row_d = row_q + IDX_W'(1);
                end
            end else begin
                col_d = col_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col_q        <= '0;
            row_q        <= '0;
            len_q        <= LEN_MAX;
            h_q          <= '1;
            idle_q       <= 1'b1;
            out_valid_q  <= 1'b0;
            col_data_q   <= '0;
            col_idx_q    <= '0;
            row_idx_q    <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            len_q        <= len_d;
            h_q          <= h_d;
            idle_q       <= idle_d;
            out_valid_q  <= out_valid_d;
            col_data_q   <= col_data_d;
            col_idx_q    <= col_idx_d;
            row_idx_q    <= row_idx_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Delay-line RAM has no reset; the fill mask hides whatever it holds.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_mem[0][ptr] <= in_data;
            for (int r = 1; r < ROWS - 1; r++) begin
                line_mem[r][ptr] <= line_mem[r-1][ptr];
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign col_data   = col_data_q;
    assign col_idx    = col_idx_q;
    assign row_idx    = row_idx_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_line_buffer_window.sv
// Directed bench for line_buffer_window: a position-based pixel model feeds a
// scoreboard queue that is compared against every DUT output column.
module tb_line_buffer_window;

    localparam int DATA_W = 16;
    localparam int LINE_W = 8;
    localparam int ROWS   = 4;
    localparam int STRIDE = 2;
    localparam int IDX_W  = 8;

    logic                   clk = 1'b0;
    logic                   rst, clr, in_valid;
    logic [IDX_W-1:0]       line_len, frame_h;
    logic [DATA_W-1:0]      in_data;
    logic                   out_valid, win_valid, frame_done;
    logic [ROWS*DATA_W-1:0] col_data;
    logic [IDX_W-1:0]       col_idx, row_idx;

    line_buffer_window #(
        .DATA_W(DATA_W), .LINE_W(LINE_W), .ROWS(ROWS), .STRIDE(STRIDE), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .line_len(line_len), .frame_h(frame_h),
        .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
        .col_data(col_data), .col_idx(col_idx), .row_idx(row_idx),
        .win_valid(win_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  row;
        logic [7:0]  col;
        logic        win;
        logic        done;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_err = 0;
    bit   sb_on = 0;
    logic [63:0] last_data;
    logic [7:0]  last_row, last_col;

    int m_row, m_col, m_len, m_h;
    bit m_idle;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(int r, int c, int len, int h);
        exp_t e;
        e.data = '0;
        for (int k = 0; k < 4; k++)
            if (r >= k) e.data[k*16 +: 16] = 16'((r - k) * 16 + c);
        e.row  = 8'(r);
        e.col  = 8'(c);
        e.win  = (r >= 3) && (c >= 3) && ((r - 3) % 2 == 0) && ((c - 3) % 2 == 0);
        e.done = (c == len - 1) && (r == h - 1);
        return e;
    endfunction

    task automatic pixel();
        exp_t e;
        if (m_idle) begin
            m_len  = (line_len == 0 || line_len > LINE_W) ? LINE_W : int'(line_len);
            m_h    = (frame_h == 0) ? 255 : int'(frame_h);
            m_idle = 0;
        end
        e        = mk(m_row, m_col, m_len, m_h);
        in_valid = 1'b1;
        in_data  = 16'(m_row * 16 + m_col);
        if (m_col == m_len - 1) begin
            m_col = 0;
            if (m_row == m_h - 1) begin
                m_row  = 0;
                m_idle = 1;
            end else m_row++;
        end else m_col++;
        @(posedge clk);
        sb_q.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr(input bit with_pix);
        clr      = 1'b1;
        in_valid = with_pix;
        in_data  = 16'h00AA;
        @(posedge clk);
        #1 clr   = 1'b0;
        in_valid = 1'b0;
        m_row = 0; m_col = 0; m_idle = 1;
        last_data = '0; last_row = '0; last_col = '0;
    endtask

    always @(negedge clk) begin
        if (sb_on) begin
            chk("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
            if (out_valid && sb_q.size() != 0) begin
                cur = sb_q.pop_front();
                chk($sformatf("col_data@%0d,%0d", cur.row, cur.col), col_data, cur.data);
                chk("row_idx", 64'(row_idx), 64'(cur.row));
                chk("col_idx", 64'(col_idx), 64'(cur.col));
                chk($sformatf("win_valid@%0d,%0d", cur.row, cur.col), 64'(win_valid), 64'(cur.win));
                chk($sformatf("frame_done@%0d,%0d", cur.row, cur.col), 64'(frame_done), 64'(cur.done));
                last_data = cur.data; last_row = cur.row; last_col = cur.col;
            end else if (!out_valid) begin
                chk("hold_col_data", col_data, last_data);
                chk("hold_row_idx", 64'(row_idx), 64'(last_row));
                chk("hold_col_idx", 64'(col_idx), 64'(last_col));
                chk("idle_win_valid", 64'(win_valid), 64'd0);
                chk("idle_frame_done", 64'(frame_done), 64'd0);
            end
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        line_len = 8'd6; frame_h = 8'd6;
        m_row = 0; m_col = 0; m_idle = 1; m_len = 6; m_h = 6;
        last_data = '0; last_row = '0; last_col = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_win_valid", 64'(win_valid), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_col_data", col_data, 64'd0);
        chk("rst_row_idx", 64'(row_idx), 64'd0);
        chk("rst_col_idx", 64'(col_idx), 64'd0);
        sb_on = 1;

        // Dense 6x6 frame, then first pixel of the next frame
        for (int i = 0; i < 37; i++) pixel();
        idle_cycle(); idle_cycle();
        do_clr(0);
        idle_cycle();

        // line_len change mid-frame is ignored: wrap stays at col 5
        for (int i = 0; i < 13; i++) pixel();
        line_len = 8'd4;
        for (int i = 0; i < 7; i++) pixel();
        line_len = 8'd6;
        do_clr(0);

        // clr with in_valid at (2,3): pixel dropped, next pixel restarts at (0,0)
        for (int i = 0; i < 15; i++) pixel();
        do_clr(1);
        idle_cycle();
        pixel();
        pixel();
        do_clr(0);

        // Gappy full frame
        for (int n = 0; n < 36; ) begin
            if ($urandom_range(0, 1) == 1) begin
                pixel();
                n++;
            end else idle_cycle();
        end
        idle_cycle();

        // line_len 0 clamps to LINE_W; short frame
        line_len = 8'd0; frame_h = 8'd2;
        for (int i = 0; i < 16; i++) pixel();
        idle_cycle(); idle_cycle();

        sb_on = 0;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
